ntt_stage_ctrl: RTL and testbench

Sequencer for the in-place radix-2 NTT. It walks all LOGN stages of a Cooley-Tukey decimation-in-time transform over an N-point coefficient memory. Every cycle it issues one butterfly's read-address pair and twiddle index to the pipelined butterfly datapath, then returns the matching write-back addresses BF_LAT cycles later. Between stages it drains the pipeline so the next stage never reads a coefficient that has not yet been written back.

---
 rtl/ntt_pkg.sv | 37 +++
 rtl/ntt_addr_gen.sv | 63 ++++++
 rtl/ntt_stage_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared declarations for the NTT stage sequencer.
//   - ntt_state_e        : sequencer states (IDLE, ISSUE, DRAIN, DONE)
//   - NTT_*_DEFAULT      : default transform size and butterfly latency
//   - ntt_addr_w()       : address width (and stage count) for an N-point transform
//   - ntt_stage_w()      : width of the stage number for an N-point transform
//   - ntt_addr_bundle_t  : {valid, addr_a, addr_b} carried down the write-back delay line
// Optional feature macro used by the top level: NTT_CTRL_INV_EN.
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ntt_state_e;

    localparam int NTT_N_DEFAULT      = 256;
    localparam int NTT_BF_LAT_DEFAULT = 4;

    // Widest address the bundle can carry; the top uses the low LOGN bits.
    localparam int NTT_MAX_LOGN = 16;

    function automatic int ntt_addr_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int ntt_stage_w(input int n);
        return $clog2($clog2(n));
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [NTT_MAX_LOGN-1:0] addr_a;
        logic [NTT_MAX_LOGN-1:0] addr_b;
    } ntt_addr_bundle_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: butterfly address / twiddle generator, one register stage.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   en               : load computed values this edge (otherwise outputs load 0)
//   inv              : emit the negated twiddle index (N - idx) mod N
//   s, k             : stage number and butterfly index within the stage
//   addr_a, addr_b   : registered operand addresses for butterfly (s, k)
//   tw_idx           : registered twiddle ROM index for butterfly (s, k)
module ntt_addr_gen #(
    parameter int LOGN = 8,
    parameter int SW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            inv,
    input  logic [SW-1:0]   s,
    input  logic [LOGN-1:0] k,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-1:0] tw_idx
);

    localparam logic [LOGN-1:0] ONE = LOGN'(1);

    logic [LOGN-1:0] half;
    logic [LOGN-1:0] lo;
    logic [LOGN-1:0] a_c;
    logic [LOGN-1:0] b_c;
    logic [LOGN-1:0] tw_sh;
    logic [LOGN-1:0] tw_f;
    logic [LOGN-1:0] tw_c;

    always_comb begin
        half  = ONE << s;
        lo    = k & (half - ONE);
        // Group base (k >> s) * 2 * half, done as two shifts so that the
        // shift amount never needs s+1 (which would wrap at SW bits).
        a_c   = (((k >> s) << s) << 1) | lo;
        b_c   = a_c + half;
        tw_sh = LOGN'(LOGN - 1) - LOGN'(s);
        tw_f  = lo << tw_sh;
        // Two's-complement negate at LOGN bits is (N - idx) mod N; 0 stays 0.
        tw_c  = inv ? (LOGN'(0) - tw_f) : tw_f;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_a <= '0;
            addr_b <= '0;
            tw_idx <= '0;
        end else if (en) begin
            addr_a <= a_c;
            addr_b <= b_c;
            tw_idx <= tw_c;
        end else begin
            addr_a <= '0;
            addr_b <= '0;
            tw_idx <= '0;
        end
    end

endmodule

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: sequencer for an in-place radix-2 DIT NTT over N points.
// Walks LOGN stages, issuing one butterfly per cycle (read pair + twiddle
// index), returns the write-back pair BF_LAT cycles later, and drains the
// butterfly pipeline between stages.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   inverse                 : (only with NTT_CTRL_INV_EN) select inverse twiddles,
//                             captured at start
//   start                   : begin a transform, sampled only in IDLE
//   busy, done              : transform in progress / one-cycle completion pulse
//   stage                   : current stage number
//   rd_valid, rd_addr_a/b   : butterfly issue strobe and operand addresses
//   tw_idx                  : twiddle ROM index
//   wr_valid, wr_addr_a/b   : write-back strobe and addresses
//   dbg_state               : current sequencer state (ntt_state_e encoding)
// Optional feature macro: NTT_CTRL_INV_EN.
//
// Handshake: strobes only, no back-pressure. rd_valid marks a cycle in which
// rd_addr_a/rd_addr_b/tw_idx describe one butterfly; wr_valid marks a cycle in
// which wr_addr_a/wr_addr_b must be written. Addresses are 0 when not valid.
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter  int N      = NTT_N_DEFAULT,
    parameter  int BF_LAT = NTT_BF_LAT_DEFAULT,
    localparam int LOGN   = ntt_addr_w(N),
    localparam int SW     = ntt_stage_w(N)
) (
    input  logic            clk,
    input  logic            reset,
`ifdef NTT_CTRL_INV_EN
    input  logic            inverse,
`endif
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [SW-1:0]   stage,
    output logic            rd_valid,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_idx,
    output logic            wr_valid,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b,
    output logic [1:0]      dbg_state
);

    localparam int              DW     = $clog2(BF_LAT + 1);
    localparam logic [LOGN-1:0] HALF_N = LOGN'(N / 2);
    localparam logic [SW-1:0]   LAST_S = SW'(LOGN - 1);
    localparam logic [DW-1:0]   DLAST  = DW'(BF_LAT - 1);

    ntt_state_e      state;
    logic [DW-1:0]   dcnt;
    // s_la/k_la run one butterfly ahead of the outputs: the address generator
    // registers its result, so it must see (s, k) one edge before issue.
    logic [SW-1:0]   s_la;
    logic [LOGN-1:0] k_la;
    logic            issue_next;
    logic            inv_sel;

    assign dbg_state = state;

    // High when the coming edge starts (or continues) an ISSUE cycle.
    always_comb begin
        issue_next = 1'b0;
        case (state)
            IDLE:    issue_next = start;
            ISSUE:   issue_next = (k_la != HALF_N);
            DRAIN:   issue_next = (dcnt == DLAST) && (stage != LAST_S);
            default: issue_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dcnt     <= '0;
            s_la     <= '0;
            k_la     <= '0;
            stage    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= issue_next;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        stage <= '0;
                        k_la  <= LOGN'(1);
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (k_la == HALF_N) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                        k_la  <= '0;
                        s_la  <= (stage == LAST_S) ? '0 : stage + SW'(1);
                    end else begin
                        k_la <= k_la + LOGN'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt == DLAST) begin
                        if (stage == LAST_S) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            stage <= stage + SW'(1);
                            k_la  <= LOGN'(1);
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    stage <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NTT_CTRL_INV_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else if (state == IDLE && start) begin
            inv_q <= inverse;
        end
    end

    // The first butterfly is registered on the start edge itself, before
    // inv_q holds the captured value.
    assign inv_sel = (state == IDLE) ? inverse : inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    ntt_addr_gen #(
        .LOGN (LOGN),
        .SW   (SW)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (issue_next),
        .inv    (inv_sel),
        .s      (s_la),
        .k      (k_la),
        .addr_a (rd_addr_a),
        .addr_b (rd_addr_b),
        .tw_idx (tw_idx)
    );

    // Write-back delay line: entry BF_LAT-1 is the issue of BF_LAT cycles ago.
    ntt_addr_bundle_t rd_bundle;
    ntt_addr_bundle_t dly [BF_LAT];

    always_comb begin
        rd_bundle                  = '0;
        rd_bundle.valid            = rd_valid;
        rd_bundle.addr_a[LOGN-1:0] = rd_addr_a;
        rd_bundle.addr_b[LOGN-1:0] = rd_addr_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BF_LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= rd_bundle;
            for (int i = 1; i < BF_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign wr_valid  = dly[BF_LAT-1].valid;
    assign wr_addr_a = dly[BF_LAT-1].addr_a[LOGN-1:0];
    assign wr_addr_b = dly[BF_LAT-1].addr_b[LOGN-1:0];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl: self-checking bench for ntt_stage_ctrl with N=8, BF_LAT=2.
// Expected behaviour comes from a cycle-indexed model of the transform
// schedule and butterfly pairing; write-backs are matched against a queue of
// issued pairs. Build with NTT_CTRL_INV_EN defined to exercise inverse twiddles.
module tb_ntt_stage_ctrl;
    import ntt_pkg::*;

    localparam int N      = 8;
    localparam int BF     = 2;
    localparam int LOGN   = 3;
    localparam int SW     = 2;
    localparam int HALF   = N / 2;
    localparam int PER    = HALF + BF;
    localparam int DONE_C = LOGN * PER + 1;
    localparam int LAST_C = DONE_C + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic start;
`ifdef NTT_CTRL_INV_EN
    logic inverse;
`endif
    logic            busy;
    logic            done;
    logic [SW-1:0]   stage;
    logic            rd_valid;
    logic [LOGN-1:0] rd_addr_a;
    logic [LOGN-1:0] rd_addr_b;
    logic [LOGN-1:0] tw_idx;
    logic            wr_valid;
    logic [LOGN-1:0] wr_addr_a;
    logic [LOGN-1:0] wr_addr_b;
    logic [1:0]      dbg_state;

    always #5 clk = ~clk;

    ntt_stage_ctrl #(
        .N      (N),
        .BF_LAT (BF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef NTT_CTRL_INV_EN
        .inverse   (inverse),
`endif
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_valid  (rd_valid),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_valid  (wr_valid),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [2*LOGN-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference: what the sequencer presents in cycle c of a transform
    // (cycle 1 = first cycle after the start edge).
    function automatic void model_cycle(input int c, input logic inv,
                                        output logic e_rd,
                                        output logic [LOGN-1:0] e_a,
                                        output logic [LOGN-1:0] e_b,
                                        output logic [LOGN-1:0] e_tw,
                                        output logic [SW-1:0] e_s);
        int s, k, half, g, j, a, b, tw;
        e_rd = 1'b0; e_a = '0; e_b = '0; e_tw = '0; e_s = '0;
        if (c >= 1) begin
            s = (c - 1) / PER;
            k = (c - 1) % PER;
            if (s < LOGN && k < HALF) begin
                half = 1 << s;
                g    = k / half;
                j    = k % half;
                a    = g * 2 * half + j;
                b    = a + half;
                tw   = j * (N / (2 * half));
                if (inv) tw = (N - tw) % N;
                e_rd = 1'b1;
                e_a  = a[LOGN-1:0];
                e_b  = b[LOGN-1:0];
                e_tw = tw[LOGN-1:0];
                e_s  = s[SW-1:0];
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    // noise: 0 none, 1 start pulse in cycle 5, 2 random start pulses while busy.
    // hold: leave start high throughout (back-to-back transforms).
    task automatic run_transform(input logic inv, input int noise, input bit hold);
        logic e_rd, e_wr;
        logic [LOGN-1:0] e_a, e_b, e_tw, x_a, x_b, x_tw;
        logic [SW-1:0] e_s, x_s;
        logic [2*LOGN-1:0] want;
        logic e_busy, e_done;
        int n_rd, n_wr;
        n_rd = 0;
        n_wr = 0;
        start = 1'b1;
`ifdef NTT_CTRL_INV_EN
        inverse = inv;
`endif
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
`ifdef NTT_CTRL_INV_EN
        inverse = ~inv;
`endif
        for (int c = 1; c <= LAST_C; c++) begin
            model_cycle(c, inv, e_rd, e_a, e_b, e_tw, e_s);
            model_cycle(c - BF, inv, e_wr, x_a, x_b, x_tw, x_s);
            e_busy = (c <= DONE_C);
            e_done = (c == DONE_C);
            n_checks++;
            if ({busy, done, rd_valid, wr_valid} !== {e_busy, e_done, e_rd, e_wr}) begin
                n_fail++;
                $display("FAIL ctrl cycle %0d: busy/done/rd/wr got %b want %b", c,
                         {busy, done, rd_valid, wr_valid}, {e_busy, e_done, e_rd, e_wr});
            end
            if (e_rd) begin
                n_checks++;
                if ({rd_addr_a, rd_addr_b, tw_idx, stage} !== {e_a, e_b, e_tw, e_s}) begin
                    n_fail++;
                    $display("FAIL issue cycle %0d: a=%0d b=%0d tw=%0d s=%0d want a=%0d b=%0d tw=%0d s=%0d",
                             c, rd_addr_a, rd_addr_b, tw_idx, stage, e_a, e_b, e_tw, e_s);
                end
                exp_q.push_back({e_a, e_b});
            end
            if (rd_valid === 1'b1) n_rd++;
            if (wr_valid === 1'b1) begin
                n_wr++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL writeback cycle %0d: got a=%0d b=%0d with nothing outstanding",
                             c, wr_addr_a, wr_addr_b);
                end else begin
                    want = exp_q.pop_front();
                    if ({wr_addr_a, wr_addr_b} !== want) begin
                        n_fail++;
                        $display("FAIL writeback cycle %0d: got a=%0d b=%0d want a=%0d b=%0d",
                                 c, wr_addr_a, wr_addr_b, want[2*LOGN-1:LOGN], want[LOGN-1:0]);
                    end
                end
            end
            if (noise == 1) start = (c == 5);
            if (noise == 2) start = (c >= 2 && c <= DONE_C) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (c < LAST_C) begin
                @(posedge clk); #1;
            end
        end
        if (!hold) start = 1'b0;
        n_checks++;
        if (n_rd != HALF * LOGN || n_wr != HALF * LOGN || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL counts: rd=%0d wr=%0d left=%0d want rd=%0d wr=%0d left=0",
                     n_rd, n_wr, exp_q.size(), HALF * LOGN, HALF * LOGN);
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL end state: got %0d want %0d", dbg_state, IDLE);
        end
    endtask

    // Start a transform, then assert reset (with start also high) in cycle abort_c.
    task automatic run_abort(input int abort_c);
        logic e_rd;
        logic [LOGN-1:0] e_a, e_b, e_tw;
        logic [SW-1:0] e_s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= abort_c; c++) begin
            model_cycle(c, 1'b0, e_rd, e_a, e_b, e_tw, e_s);
            n_checks++;
            if ({busy, rd_valid} !== {1'b1, e_rd}) begin
                n_fail++;
                $display("FAIL pre-abort cycle %0d: busy/rd got %b want %b", c,
                         {busy, rd_valid}, {1'b1, e_rd});
            end
            if (c < abort_c) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        n_checks++;
        if ({busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_idx,
             wr_valid, wr_addr_a, wr_addr_b, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL after abort: busy=%b done=%b s=%0d rd=%b a=%0d b=%0d tw=%0d wr=%b wa=%0d wb=%0d st=%0d want all 0",
                     busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_idx,
                     wr_valid, wr_addr_a, wr_addr_b, dbg_state);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, done, rd_valid, wr_valid} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle after abort +%0d: busy/done/rd/wr got %b want 0000", i,
                         {busy, done, rd_valid, wr_valid});
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
`ifdef NTT_CTRL_INV_EN
        inverse = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_idx,
                 wr_valid, wr_addr_a, wr_addr_b, dbg_state} !== '0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: busy=%b done=%b s=%0d rd=%b a=%0d b=%0d tw=%0d wr=%b wa=%0d wb=%0d st=%0d want all 0",
                         i, busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_idx,
                         wr_valid, wr_addr_a, wr_addr_b, dbg_state);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, rd_valid, wr_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL post-reset idle %0d: busy/rd/wr got %b want 000", i,
                         {busy, rd_valid, wr_valid});
            end
        end
    endtask

    task automatic test_full_run;
        run_transform(1'b0, 0, 1'b0);
    endtask

    task automatic test_start_ignored;
        run_transform(1'b0, 1, 1'b0);
    endtask

    task automatic test_abort;
        run_abort(8);
        run_transform(1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_transform(1'b0, 0, 1'b1);
        run_transform(1'b0, 0, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_inverse;
`ifdef NTT_CTRL_INV_EN
        run_transform(1'b1, 0, 1'b0);
        run_transform(1'b0, 0, 1'b0);
`endif
    endtask

    task automatic test_random;
        logic inv;
        int gap;
        for (int it = 0; it < 8; it++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            inv = 1'b0;
`ifdef NTT_CTRL_INV_EN
            inv = ($urandom_range(0, 1) == 1);
`endif
            if ($urandom_range(0, 3) == 0) begin
                run_abort($urandom_range(1, DONE_C - 1));
            end else begin
                run_transform(inv, 2, 1'b0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
`ifdef NTT_CTRL_INV_EN
        inverse = 1'b0;
`endif
        test_reset;
        test_full_run;
        test_start_ignored;
        test_abort;
        test_back_to_back;
        test_inverse;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
